bfly_burst_ctrl: RTL

- Sequences the radix-2 butterfly datapath.
- Pulls complete beat-bursts from an upstream first-word-fall-through (FWFT) sample FIFO.
- Drives the datapath's valid strobe as uninterrupted NUM_PAIR/2-beat bursts, with at least one idle gap between bursts.
- Checks that the datapath's twiddle_valid strobe lands on the expected cycle.
- Holds a credit count so it never launches a burst the downstream twiddle stage cannot absorb.

---
 rtl/bfly_burst_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bfly_burst_ctrl.sv
// Burst sequencer for the radix-2 butterfly datapath.
// Launches fixed-length beat bursts from an FWFT FIFO under a credit budget.
module bfly_burst_ctrl #(
    parameter int NUM_PAIR   = 16,
    parameter int CREDIT_MAX = 16,
    parameter int FIFO_AW    = 5,
    parameter int GAP_CYC    = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic [FIFO_AW:0]              fifo_level,
    output logic                          fifo_rd,
    output logic                          bfly_valid,
    input  logic                          twiddle_valid,
    input  logic                          credit_ret,
    output logic [$clog2(CREDIT_MAX):0]   credit_cnt,
    output logic                          busy,
    output logic                          burst_done,
    output logic [15:0]                   burst_cnt,
    output logic                          err
);

    localparam int BURST_LEN = NUM_PAIR / 2;
    localparam int CW = $clog2(CREDIT_MAX) + 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GW = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

    localparam logic [FIFO_AW:0] LVL_BL = (FIFO_AW + 1)'(BURST_LEN);
    localparam logic [CW-1:0]    CR_BL  = CW'(BURST_LEN);
    localparam logic [CW-1:0]    CR_MAX = CW'(CREDIT_MAX);
    localparam logic [BW-1:0]    BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0]    GAP_LAST  = GW'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        CHECK,
        GAP
    } state_t;

    state_t          state, state_n;
    logic [BW-1:0]   beat, beat_n;
    logic [GW-1:0]   gap, gap_n;
    logic            valid_n;
    logic            done_n;
    logic            busy_n;
    logic            err_n;
    logic [15:0]     bcnt_n;
    logic [CW-1:0]   credit_n;
    logic            can_launch;
    logic            launch;
    logic            ret_ok;
    logic            ret_ovf;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            beat       <= '0;
            gap        <= '0;
            bfly_valid <= 1'b0;
            fifo_rd    <= 1'b0;
            burst_done <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            burst_cnt  <= '0;
            credit_cnt <= CR_MAX;
        end else begin
            state      <= state_n;
            beat       <= beat_n;
            gap        <= gap_n;
            bfly_valid <= valid_n;
            fifo_rd    <= valid_n;
            burst_done <= done_n;
            busy       <= busy_n;
            err        <= err_n;
            burst_cnt  <= bcnt_n;
            credit_cnt <= credit_n;
        end
    end

    // Launch may be evaluated in the last idle-gap cycle so the gap is exact
    always_comb begin
        can_launch = 1'b0;
        unique case (state)
            IDLE:    can_launch = 1'b1;
            CHECK:   can_launch = (GAP_CYC == 1);
            GAP:     can_launch = (gap == GAP_LAST);
            default: can_launch = 1'b0;
        endcase
    end

    assign launch = can_launch && en
                 && (fifo_level >= LVL_BL)
                 && (credit_cnt >= CR_BL);

    assign ret_ovf = credit_ret && (credit_cnt == CR_MAX);
    assign ret_ok  = credit_ret && !ret_ovf;

    always_comb begin
        credit_n = credit_cnt;
        unique case (1'b1)
            launch && ret_ok:  credit_n = credit_cnt - CR_BL + CW'(1);
            launch && !ret_ok: credit_n = credit_cnt - CR_BL;
            !launch && ret_ok: credit_n = credit_cnt + CW'(1);
            default:           credit_n = credit_cnt;
        endcase
    end

    always_comb begin
        state_n = state;
        beat_n  = beat;
        gap_n   = gap;
        valid_n = 1'b0;
        done_n  = 1'b0;
        bcnt_n  = burst_cnt;
        err_n   = err;

        unique case (state)
            IDLE: begin
            end
            BURST: begin
                if (beat == BEAT_LAST) begin
                    state_n = CHECK;
                end else begin
                    beat_n  = beat + BW'(1);
                    valid_n = 1'b1;
                end
            end
            CHECK: begin
                if (twiddle_valid) begin
                    done_n = 1'b1;
                    bcnt_n = burst_cnt + 16'd1;
                end else begin
                    err_n = 1'b1;
                end
                if (GAP_CYC > 1) begin
                    state_n = GAP;
                    gap_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            GAP: begin
                if (gap == GAP_LAST) begin
                    state_n = IDLE;
                end else begin
                    gap_n = gap + GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (launch) begin
            state_n = BURST;
            beat_n  = '0;
            valid_n = 1'b1;
        end

        // Twiddle strobe outside the check slot means the datapath lost sync
        if (twiddle_valid && (state != CHECK)) begin
            err_n = 1'b1;
        end
        if (ret_ovf) begin
            err_n = 1'b1;
        end

        busy_n = (state_n != IDLE);
    end

endmodule
